// File: rtl/riscv_lrsc_resv_table.sv
// Multi-hart LR/SC reservation table for the RV64A load/store path.
// Each hart owns one reservation (valid, exact address, size, expiry timer).
// The table decides SC success combinationally in the request cycle, drives
// the SC write qualifier and the SC rd value, and invalidates reservations on
// stores/AMOs, passing SCs, external snoops, per-hart flushes and timeouts.
module riscv_lrsc_resv_table #(
  parameter int NUM_HARTS    = 2,
  parameter int XLEN         = 64,
  parameter int GRANULE_LOG2 = 3,
  parameter int TIMEOUT      = 16,
  localparam int HW          = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 i_riscv_lrsc_clk,
  input  logic                 i_riscv_lrsc_rst,
  input  logic                 i_riscv_lrsc_req_valid,
  input  logic [HW-1:0]        i_riscv_lrsc_req_hart,
  input  logic [1:0]           i_riscv_lrsc_req_op,
  input  logic                 i_riscv_lrsc_req_dword,
  input  logic [XLEN-1:0]      i_riscv_lrsc_req_addr,
  input  logic                 i_riscv_lrsc_kill,
  input  logic [NUM_HARTS-1:0] i_riscv_lrsc_flush,
  input  logic                 i_riscv_lrsc_snoop_valid,
  input  logic [XLEN-1:0]      i_riscv_lrsc_snoop_addr,
  output logic                 o_riscv_lrsc_sc_pass,
  output logic                 o_riscv_lrsc_sc_rdvalue,
  output logic [1:0]           o_riscv_lrsc_sc_cause,
  output logic [NUM_HARTS-1:0] o_riscv_lrsc_resv_valid
);

  localparam logic [1:0] OP_STORE = 2'b00;
  localparam logic [1:0] OP_LR    = 2'b01;
  localparam logic [1:0] OP_SC    = 2'b10;
  localparam logic [1:0] OP_AMO   = 2'b11;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_NORESV = 2'b01;
  localparam logic [1:0] CAUSE_ADDR   = 2'b10;
  localparam logic [1:0] CAUSE_SIZE   = 2'b11;

  // A zero-width timer is illegal, so TIMEOUT==0 keeps one unused bit.
  localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_INIT = TW'(TIMEOUT);
  localparam int            GW         = XLEN - GRANULE_LOG2;

  // Reservation state per hart.
  logic [NUM_HARTS-1:0] valid_q, valid_d;
  logic [NUM_HARTS-1:0] dword_q, dword_d;
  logic [XLEN-1:0]      addr_q  [NUM_HARTS];
  logic [XLEN-1:0]      addr_d  [NUM_HARTS];
  logic [TW-1:0]        timer_q [NUM_HARTS];
  logic [TW-1:0]        timer_d [NUM_HARTS];

  // Request decode.
  logic                 acc;
  logic                 is_sc;
  logic                 is_wr;
  logic                 snoop_hits_req;
  logic                 sel_valid;
  logic                 sel_dword;
  logic [XLEN-1:0]      sel_addr;
  logic                 no_resv;
  logic                 addr_mis;
  logic                 size_mis;
  logic                 sc_pass;
  logic [NUM_HARTS-1:0] hart_sel;
  logic [NUM_HARTS-1:0] req_gran_match;
  logic [NUM_HARTS-1:0] snp_gran_match;
  logic [NUM_HARTS-1:0] lr_set;
  logic [NUM_HARTS-1:0] clr;

  function automatic logic [GW-1:0] gran(input logic [XLEN-1:0] a);
    return a[XLEN-1:GRANULE_LOG2];
  endfunction

  // Select the requesting hart's reservation and compare granules for all harts.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path through this block leaves a value held and no latch is inferred.
    sel_valid      = 1'b0;
    sel_dword      = 1'b0;
    sel_addr       = '0;
    hart_sel       = '0;
    req_gran_match = '0;
    snp_gran_match = '0;
    for (int g = 0; g < NUM_HARTS; g++) begin
      hart_sel[g]       = (i_riscv_lrsc_req_hart == HW'(g));
      req_gran_match[g] = (gran(addr_q[g]) == gran(i_riscv_lrsc_req_addr));
      snp_gran_match[g] = (gran(addr_q[g]) == gran(i_riscv_lrsc_snoop_addr));
      if (hart_sel[g]) begin
        sel_valid = valid_q[g] & ~i_riscv_lrsc_flush[g];
        sel_dword = dword_q[g];
        sel_addr  = addr_q[g];
      end
    end
  end

  // SC outcome for the current request, with cause priority
  // no reservation > address mismatch > size mismatch.
  always_comb begin
    acc            = i_riscv_lrsc_req_valid & ~i_riscv_lrsc_kill;
    is_sc          = i_riscv_lrsc_req_valid & (i_riscv_lrsc_req_op == OP_SC);
    is_wr          = (i_riscv_lrsc_req_op == OP_STORE) | (i_riscv_lrsc_req_op == OP_AMO);
    snoop_hits_req = i_riscv_lrsc_snoop_valid &
                     (gran(i_riscv_lrsc_snoop_addr) == gran(i_riscv_lrsc_req_addr));
    no_resv        = ~sel_valid | snoop_hits_req | i_riscv_lrsc_kill;
    addr_mis       = (sel_addr != i_riscv_lrsc_req_addr);
    size_mis       = (sel_dword != i_riscv_lrsc_req_dword);
    sc_pass        = acc & is_sc & ~no_resv & ~addr_mis & ~size_mis;

    o_riscv_lrsc_sc_pass    = sc_pass;
    o_riscv_lrsc_sc_rdvalue = is_sc & ~sc_pass;
    if (!is_sc)        o_riscv_lrsc_sc_cause = CAUSE_NONE;
    else if (no_resv)  o_riscv_lrsc_sc_cause = CAUSE_NORESV;
    else if (addr_mis) o_riscv_lrsc_sc_cause = CAUSE_ADDR;
    else if (size_mis) o_riscv_lrsc_sc_cause = CAUSE_SIZE;
    else               o_riscv_lrsc_sc_cause = CAUSE_NONE;
  end

  // Per-hart set and clear requests for the coming edge.
  always_comb begin
    lr_set = '0;
    clr    = '0;
    for (int g = 0; g < NUM_HARTS; g++) begin
      lr_set[g] = acc & (i_riscv_lrsc_req_op == OP_LR) & hart_sel[g];
      // A snoop kills both the stored granule and one being set this cycle.
      clr[g] = i_riscv_lrsc_flush[g]
             | (i_riscv_lrsc_snoop_valid & (snp_gran_match[g] | (lr_set[g] & snoop_hits_req)))
             | (acc & (i_riscv_lrsc_req_op == OP_SC) & hart_sel[g])
             | (sc_pass & req_gran_match[g])
             | (acc & is_wr & req_gran_match[g]);
    end
  end

  // Next state: clear > LR set > timer countdown.
  always_comb begin
    valid_d = valid_q;
    dword_d = dword_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    for (int g = 0; g < NUM_HARTS; g++) begin
      if (clr[g]) begin
        valid_d[g] = 1'b0;
      end else if (lr_set[g]) begin
        valid_d[g] = 1'b1;
        dword_d[g] = i_riscv_lrsc_req_dword;
        addr_d[g]  = i_riscv_lrsc_req_addr;
        timer_d[g] = TIMER_INIT;
      end else if ((TIMEOUT != 0) && valid_q[g]) begin
        if (timer_q[g] == TW'(1)) valid_d[g] = 1'b0;
        else                      timer_d[g] = timer_q[g] - TW'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_riscv_lrsc_clk or posedge i_riscv_lrsc_rst) begin
    if (i_riscv_lrsc_rst) begin
      valid_q <= '0;
      dword_q <= '0;
      // NOTE: these per-hart arrays are control state compared on every
      // request, so they are reset like flops rather than left as RAM.
      for (int g = 0; g < NUM_HARTS; g++) begin
        addr_q[g]  <= '0;
        timer_q[g] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge next-state values regardless of statement order.
      valid_q <= valid_d;
      dword_q <= dword_d;
      for (int g = 0; g < NUM_HARTS; g++) begin
        addr_q[g]  <= addr_d[g];
        timer_q[g] <= timer_d[g];
      end
    end
  end

  assign o_riscv_lrsc_resv_valid = valid_q;

endmodule
